// File: rtl/apuf_eval_if.sv
// apuf_eval_if: host-side start/seed request and busy/done/resp result bundle for apuf_eval_ctrl
interface apuf_eval_if #(
    parameter int CHAL_W = 45,
    parameter int RESP_W = 8
);
    logic              start;
    logic [CHAL_W-1:0] chal_seed;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] resp;
    modport master (output start, chal_seed, input busy, done, resp);
    modport slave  (input start, chal_seed, output busy, done, resp);
endinterface

// File: rtl/apuf_eval_ctrl.sv
// apuf_eval_ctrl: arbiter-PUF driver; LFSR challenges, X/Y launch edges, synchronized sampling into resp
// Optional per-bit majority voting over VOTE_N evaluations with macro APUF_MAJORITY_VOTE_EN
module apuf_eval_ctrl #(
    parameter int                CHAL_W     = 45,
    parameter int                RESP_W     = 8,
    parameter int                SETTLE_CYC = 4,
    parameter logic [CHAL_W-1:0] LFSR_TAPS  = 45'h1B0000000000,
    parameter int                VOTE_N     = 5
) (
    input  logic              clk,
    input  logic              rst,
    apuf_eval_if.slave        host,
    output logic [CHAL_W-1:0] o_apuf_chal,
    output logic              o_apuf_x,
    output logic              o_apuf_y,
    input  logic              i_apuf_q
);
    localparam int CW = $clog2(SETTLE_CYC + 2);
    localparam int KW = RESP_W > 1 ? $clog2(RESP_W) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, RELAX, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [KW-1:0]     r_k;
    logic [CHAL_W-1:0] r_chal;
    logic [RESP_W-1:0] r_resp;
    logic [1:0]        r_sync;
    logic              r_x;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;
    logic              w_fire_end;
    logic              w_relax_end;
    logic              w_bit_end;
    logic              w_bit_val;
    logic [CHAL_W-1:0] w_lfsr;

    assign w_accept    = r_state == IDLE && host.start;
    assign w_fire_end  = r_state == FIRE && r_cnt == CW'(SETTLE_CYC + 1);
    assign w_relax_end = r_state == RELAX && r_cnt == CW'(SETTLE_CYC - 1);
    assign w_lfsr      = {r_chal[CHAL_W-2:0], ^(r_chal & LFSR_TAPS)};

`ifdef APUF_MAJORITY_VOTE_EN
    localparam int VW = $clog2(VOTE_N + 1);
    logic [VW-1:0] r_ones;
    logic [VW-1:0] r_vote;
    assign w_bit_end = r_vote == VW'(VOTE_N - 1);
    assign w_bit_val = r_ones > VW'(VOTE_N / 2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= '0;
            r_vote <= '0;
        end else if (w_accept || (w_relax_end && w_bit_end)) begin
            r_ones <= '0;
            r_vote <= '0;
        end else begin
            if (w_fire_end) r_ones <= r_ones + VW'(r_sync[1]);
            if (w_relax_end) r_vote <= r_vote + 1'b1;
        end
    end
`else
    logic r_bit;
    assign w_bit_end = 1'b1;
    assign w_bit_val = r_bit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bit <= 1'b0;
        else if (w_fire_end) r_bit <= r_sync[1];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_chal  <= '0;
            r_resp  <= '0;
            r_sync  <= '0;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_apuf_q};
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_chal  <= host.chal_seed == '0 ? CHAL_W'(1) : host.chal_seed;
                    r_resp  <= '0;
                    r_k     <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SETUP;
                end
                SETUP: if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                    r_cnt   <= '0;
                    r_x     <= 1'b1;
                    r_state <= FIRE;
                end else r_cnt <= r_cnt + 1'b1;
                FIRE: if (w_fire_end) begin
                    r_cnt   <= '0;
                    r_x     <= 1'b0;
                    r_state <= RELAX;
                end else r_cnt <= r_cnt + 1'b1;
                RELAX: if (w_relax_end) begin
                    r_cnt <= '0;
                    if (!w_bit_end) r_state <= SETUP;
                    else begin
                        r_resp[r_k] <= w_bit_val;
                        // the final bit leaves the challenge untouched
                        if (r_k == KW'(RESP_W - 1)) r_state <= DONE;
                        else begin
                            r_k     <= r_k + 1'b1;
                            r_chal  <= w_lfsr;
                            r_state <= SETUP;
                        end
                    end
                end else r_cnt <= r_cnt + 1'b1;
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign host.busy   = r_busy;
    assign host.done   = r_done;
    assign host.resp   = r_resp;
    assign o_apuf_chal = r_chal;
    assign o_apuf_x    = r_x;
    assign o_apuf_y    = r_x;
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// tb_apuf_eval_ctrl: randomized and directed checks of apuf_eval_ctrl against a behavioural model
module tb_apuf_eval_ctrl;
    localparam int CHAL_W = 45;
    localparam int RESP_W = 8;
    localparam int SETTLE = 4;
    localparam logic [CHAL_W-1:0] TAPS = 45'h1B0000000000;
`ifdef APUF_MAJORITY_VOTE_EN
    localparam int EVALS = 5;
`else
    localparam int EVALS = 1;
`endif
    localparam int EXP_DONE = RESP_W * EVALS * (3 * SETTLE + 2) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic apuf_q = 1'b0;
    logic apuf_x, apuf_y;
    logic [CHAL_W-1:0] apuf_chal;
    int total = 0;
    int bad = 0;

    apuf_eval_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();

    apuf_eval_ctrl dut (
        .clk(clk), .rst(rst), .host(bus),
        .o_apuf_chal(apuf_chal), .o_apuf_x(apuf_x), .o_apuf_y(apuf_y), .i_apuf_q(apuf_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CHAL_W-1:0] lfsr_step(input logic [CHAL_W-1:0] c);
        return {c[CHAL_W-2:0], ^(c & TAPS)};
    endfunction

    // mode 0: q=1; mode 1: q=parity(chal & mask); mode 2: q=1,0,1,0.. per evaluation within a bit
    task automatic run_eval(input string tag, input logic [CHAL_W-1:0] seed, input int mode,
                            input logic [CHAL_W-1:0] mask, input int repulse_at, input int rst_at);
        logic [CHAL_W-1:0] exp_c [RESP_W];
        logic [RESP_W-1:0] exp_resp;
        logic [CHAL_W-1:0] prev_chal;
        logic prev_x = 1'b0;
        int n = 0, done_n = -1, done_cnt = 0, rises = 0, xy_bad = 0, chal_bad = 0, ones;
        exp_c[0] = seed == '0 ? CHAL_W'(1) : seed;
        for (int k = 1; k < RESP_W; k++) exp_c[k] = lfsr_step(exp_c[k-1]);
        ones = (EVALS + 1) / 2;
        for (int k = 0; k < RESP_W; k++)
            exp_resp[k] = mode == 0 ? 1'b1 : mode == 1 ? ^(exp_c[k] & mask) : (ones > EVALS / 2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.chal_seed = seed;
        @(negedge clk);
        bus.start = 1'b0;
        bus.chal_seed = ~seed;
        chk({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        prev_chal = apuf_chal;
        while (n < EXP_DONE + 20) begin
            if (apuf_x !== apuf_y) xy_bad++;
            if (apuf_x && prev_x && apuf_chal !== prev_chal) chal_bad++;
            if (apuf_x && !prev_x) begin
                rises++;
                if ((rises - 1) / EVALS >= RESP_W || apuf_chal !== exp_c[(rises - 1) / EVALS]) chal_bad++;
                if (mode == 2) apuf_q = ((rises - 1) % EVALS) % 2 == 0;
            end
            if (mode == 0) apuf_q = 1'b1;
            if (mode == 1) apuf_q = ^(apuf_chal & mask);
            if (bus.done) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n = n;
                    chk({tag, "_resp"}, 64'(bus.resp), 64'(exp_resp));
                    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
                    chk({tag, "_chal_final"}, 64'(apuf_chal), 64'(exp_c[RESP_W-1]));
                end
            end
            bus.start = n == repulse_at;
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst_outs"}, 64'({bus.busy, bus.done, bus.resp, apuf_x, apuf_y}), 64'd0);
                chk({tag, "_rst_chal"}, 64'(apuf_chal), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                bus.start = 1'b0;
                for (int i = 0; i < EXP_DONE + 20; i++) begin
                    @(negedge clk);
                    if (bus.done) done_cnt++;
                end
                chk({tag, "_no_done_after_rst"}, 64'(done_cnt), 64'd0);
                chk({tag, "_idle_after_rst"}, 64'({bus.busy, apuf_x}), 64'd0);
                return;
            end
            prev_x = apuf_x;
            prev_chal = apuf_chal;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_cycle"}, 64'(done_n), 64'(EXP_DONE));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_launches"}, 64'(rises), 64'(RESP_W * EVALS));
        chk({tag, "_x_eq_y"}, 64'(xy_bad), 64'd0);
        chk({tag, "_chal_seq"}, 64'(chal_bad), 64'd0);
        chk({tag, "_resp_held"}, 64'(bus.resp), 64'(exp_resp));
    endtask

    initial begin
        logic [CHAL_W-1:0] s, m;
        bus.start = 1'b0;
        bus.chal_seed = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({bus.busy, bus.done, bus.resp, apuf_x, apuf_y}), 64'd0);
        chk("reset_chal", 64'(apuf_chal), 64'd0);
        rst = 1'b0;
        run_eval("q_one", 45'h1, 0, '0, -1, -1);
        run_eval("chal0", 45'h1, 1, 45'h1, -1, -1);
        run_eval("seed0", 45'h0, 1, 45'h1, -1, -1);
        run_eval("repulse", 45'h1, 0, '0, 30, -1);
        run_eval("alt_q", 45'h5A5, 2, '0, -1, -1);
        run_eval("mid_rst", 45'h3, 0, '0, -1, 50);
        for (int r = 0; r < 6; r++) begin
            s = CHAL_W'({$urandom, $urandom});
            if (r == 2) s = '0;
            m = CHAL_W'({$urandom, $urandom});
            run_eval($sformatf("rnd%0d", r), s, int'($urandom_range(0, 2)), m, -1, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
